// File: rtl/mac_pkg.sv
// Shared definitions for the MAC cluster drain path: lane count, index width,
// default accumulator width and the drain FSM state encoding.
package mac_pkg;

  localparam int DEFAULT_ACC_WIDTH = 32;
  localparam int NUM_LANES         = 4;
  localparam int IDX_WIDTH         = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/mac_cluster_drain.sv
// Snapshots the four MAC accumulators after a settle delay, pulses their clear,
// and serialises the snapshot onto a valid/ready stream while the cluster runs on.
module mac_cluster_drain
  import mac_pkg::*;
#(
  parameter int MAC_ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [MAC_ACC_WIDTH-1:0] in0,
  input  logic [MAC_ACC_WIDTH-1:0] in1,
  input  logic [MAC_ACC_WIDTH-1:0] in2,
  input  logic [MAC_ACC_WIDTH-1:0] in3,
  output logic                     acc_clear,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [MAC_ACC_WIDTH-1:0] m_data,
  output logic [IDX_WIDTH-1:0]     m_idx,
  output logic                     m_last,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? CNT_WIDTH'(SETTLE_CYCLES - 1) : '0;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_LANES - 1);

  drain_state_e             state;
  logic [CNT_WIDTH-1:0]     cnt;
  logic [IDX_WIDTH-1:0]     idx;
  logic [MAC_ACC_WIDTH-1:0] snap [NUM_LANES];
  logic                     snap_now;

  // Zero settle snapshots straight out of IDLE on the capture edge itself.
  always_comb begin
    snap_now = 1'b0;
    if (state == IDLE && capture && SETTLE_CYCLES == 0)
      snap_now = 1'b1;
    else if (state == SETTLE && cnt == '0)
      snap_now = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      acc_clear <= 1'b0;
      m_valid   <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++)
        snap[i] <= '0;
    end else begin
      acc_clear <= 1'b0;

      // Set has priority over clear on the same edge.
      if (capture && state != IDLE)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;

      if (snap_now) begin
        snap[0]   <= in0;
        snap[1]   <= in1;
        snap[2]   <= in2;
        snap[3]   <= in3;
        acc_clear <= 1'b1;
        m_valid   <= 1'b1;
        idx       <= '0;
        state     <= DRAIN;
      end else begin
        unique case (state)
          IDLE: begin
            if (capture) begin
              cnt   <= SETTLE_LOAD;
              state <= SETTLE;
            end
          end
          SETTLE: cnt <= cnt - 1'b1;
          DRAIN: begin
            if (m_ready) begin
              if (idx == LAST_IDX) begin
                idx     <= '0;
                m_valid <= 1'b0;
                state   <= IDLE;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign m_data = snap[idx];
  assign m_idx  = idx;
  assign m_last = (idx == LAST_IDX);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mac_cluster_drain.sv
// Scoreboard bench for mac_cluster_drain: expected beats are queued at capture
// and checked against the stream on every valid cycle.
module tb_mac_cluster_drain;

  localparam int W = 32;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   idx;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         capture = 1'b0;
  logic         capture_z = 1'b0;
  logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic         m_ready = 1'b1;
  logic         clr_overrun = 1'b0;

  logic         acc_clear, m_valid, m_last, busy, overrun;
  logic [W-1:0] m_data;
  logic [1:0]   m_idx;

  logic         z_acc_clear, z_m_valid, z_m_last, z_busy, z_overrun;
  logic [W-1:0] z_m_data;
  logic [1:0]   z_m_idx;

  beat_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  mac_cluster_drain #(.MAC_ACC_WIDTH(W), .SETTLE_CYCLES(S), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .capture(capture),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .acc_clear(acc_clear), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
    .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  mac_cluster_drain #(.MAC_ACC_WIDTH(W), .SETTLE_CYCLES(0), .CNT_WIDTH(4)) dut_z (
    .clk(clk), .rst(rst), .capture(capture_z),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .acc_clear(z_acc_clear), .m_valid(z_m_valid), .m_ready(m_ready),
    .m_data(z_m_data), .m_idx(z_m_idx), .m_last(z_m_last),
    .busy(z_busy), .overrun(z_overrun), .clr_overrun(clr_overrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [W-1:0] a, b, c, d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  task automatic push_words();
    sb_q.push_back('{data: in0, idx: 2'd0});
    sb_q.push_back('{data: in1, idx: 2'd1});
    sb_q.push_back('{data: in2, idx: 2'd2});
    sb_q.push_back('{data: in3, idx: 2'd3});
  endtask

  // Full capture with m_ready high; k counts edges after the capture edge.
  task automatic drain_run(input bit isolate);
    push_words();
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    for (int k = 0; k <= S + 5; k++) begin
      check("acc_clear", acc_clear, (k == S));
      check("m_valid", m_valid, (k >= S && k <= S + 3));
      check("busy", busy, (k < S + 4));
      if (isolate && k == S)
        set_inputs(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      step(1);
    end
  endtask

  // Stream monitor: every valid cycle must present the scoreboard head.
  always @(negedge clk) begin
    if (rst && m_valid) begin
      if (sb_q.size() == 0) begin
        check("beat_unexpected", 1, 0);
      end else begin
        check("m_data", m_data, sb_q[0].data);
        check("m_idx", m_idx, sb_q[0].idx);
        check("m_last", m_last, (sb_q[0].idx == 2'd3));
        if (m_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_acc_clear", acc_clear, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_idx", m_idx, 0);
    check("rst_m_last", m_last, 0);
    check("rst_overrun", overrun, 0);
    #10 rst = 1'b1;
    step(2);

    // Basic drain
    set_inputs(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    drain_run(1'b0);

    // Backpressure: ready low for the first three valid cycles
    m_ready = 1'b0;
    push_words();
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    step(S);
    check("bp_valid", m_valid, 1);
    check("bp_acc_clear", acc_clear, 1);
    step(1);
    check("bp_acc_clear_once", acc_clear, 0);
    step(2);
    check("bp_idx_held", m_idx, 0);
    check("bp_valid_held", m_valid, 1);
    m_ready = 1'b1;
    step(4);
    check("bp_done_busy", busy, 0);
    check("bp_done_valid", m_valid, 0);
    check("bp_sb_empty", sb_q.size(), 0);

    // Snapshot isolation
    set_inputs(32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF);
    drain_run(1'b1);
    check("iso_sb_empty", sb_q.size(), 0);

    // Overrun during DRAIN at idx 2
    set_inputs(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000001, 32'h80000000);
    push_words();
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    step(S + 2);
    check("ovr_idx2", m_idx, 2);
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_no_clear", acc_clear, 0);
    check("ovr_idx3", m_idx, 3);
    step(1);
    check("ovr_idle", busy, 0);
    check("ovr_no_clear2", acc_clear, 0);
    step(1);
    check("ovr_no_redrain", m_valid, 0);
    check("ovr_no_clear3", acc_clear, 0);

    // Set and clear on the same edge during SETTLE: set wins
    push_words();
    capture = 1'b1;
    step(1);
    capture = 1'b1;
    clr_overrun = 1'b1;
    step(1);
    capture = 1'b0;
    clr_overrun = 1'b0;
    check("ovr_set_wins", overrun, 1);
    step(S + 4);
    check("ovr_drain_done", busy, 0);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Zero settle on the second instance
    set_inputs(32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F);
    capture_z = 1'b1;
    step(1);
    capture_z = 1'b0;
    check("z_acc_clear", z_acc_clear, 1);
    check("z_m_valid", z_m_valid, 1);
    check("z_m_data0", z_m_data, 32'hCAFEF00D);
    check("z_m_idx0", z_m_idx, 0);
    step(1);
    check("z_acc_clear_once", z_acc_clear, 0);
    check("z_m_data1", z_m_data, 32'h13579BDF);
    step(2);
    check("z_m_data3", z_m_data, 32'h0F0F0F0F);
    check("z_m_last", z_m_last, 1);
    step(1);
    check("z_idle", z_busy, 0);
    check("z_valid_drop", z_m_valid, 0);

    // Async reset mid-drain at idx 1
    set_inputs(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    push_words();
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    step(S + 1);
    check("ar_idx1", m_idx, 1);
    #3;
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("ar_m_valid", m_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_acc_clear", acc_clear, 0);
    check("ar_m_idx", m_idx, 0);
    check("ar_m_data", m_data, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    step(1);
    set_inputs(32'h77777777, 32'h88888888, 32'h99999999, 32'hAAAAAAAA);
    drain_run(1'b0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_cluster_drain.md
Name: mac_cluster_drain

Overview:
- Sits directly downstream of the four-lane MAC cluster.
- On a capture request, waits a programmable settle time, then snapshots the cluster's four accumulator outputs (out0..out3) and pulses a clear request back to the cluster's accumulators.
- Serialises the four snapshot words onto a single valid/ready stream toward the fabric output network.
- Frees the cluster to start the next accumulation while the previous results drain.

Parameters:
- MAC_ACC_WIDTH, 32, width of each accumulator word (matches cluster output width).
- SETTLE_CYCLES, 2, edges between capture sampling and snapshot; covers cluster pipeline latency; legal range 0..15.
- CNT_WIDTH, 4, width of settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- capture  input  1  one-cycle request to snapshot the accumulators; level-sampled each edge.
- in0  input  MAC_ACC_WIDTH  cluster out0.
- in1  input  MAC_ACC_WIDTH  cluster out1.
- in2  input  MAC_ACC_WIDTH  cluster out2.
- in3  input  MAC_ACC_WIDTH  cluster out3.
- acc_clear  output  1  one-cycle pulse; integrator ORs it into the cluster's accumulator clear.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accepts word.
- m_data  output  MAC_ACC_WIDTH  snapshot word.
- m_idx  output  2  lane index of m_data (0..3).
- m_last  output  1  high with idx 3.
- busy  output  1  high whenever state != IDLE.
- overrun  output  1  sticky: capture arrived while busy.
- clr_overrun  input  1  clears overrun.

Behaviour:
- Reset (rst low, async) forces:
  - state IDLE, settle counter 0, snapshot regs 0, idx 0.
  - acc_clear=0, m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, overrun=0.
  - Reset release is synchronous to clk; first active edge follows.
- Reset mid-drain discards all pending words. No acc_clear is issued.
- States: IDLE, SETTLE, DRAIN.
- IDLE:
  - capture=1 at edge E0 with SETTLE_CYCLES=0: snapshot regs load in0..in3 at E0; go to DRAIN.
  - capture=1 at edge E0 with SETTLE_CYCLES>0: counter loads SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - Each edge: counter==0 -> load snapshot, go to DRAIN; else counter decrements.
  - Net effect: snapshot edge is E0+SETTLE_CYCLES.
- acc_clear is registered. It is high for exactly the one cycle following the snapshot edge, never otherwise.
- DRAIN:
  - m_valid=1 from the cycle after the snapshot edge.
  - m_data = snapshot[idx]; m_idx = idx; m_last = (idx==3).
  - A beat is accepted at an edge where m_valid && m_ready.
  - Accepted beat with idx<3: idx increments.
  - Accepted beat with idx==3: idx returns to 0, m_valid drops, go to IDLE.
- Handshake rules:
  - m_data, m_idx and m_last are held stable while m_valid && !m_ready.
  - m_valid never deasserts without acceptance.
  - m_ready may be high before m_valid; this has no effect.
- Throughput and latency:
  - With m_ready held high, the four beats occupy four consecutive cycles.
  - Minimum capture-to-capture spacing is SETTLE_CYCLES+5 cycles.
  - Latency from capture to first valid is SETTLE_CYCLES+1 cycles.
- capture while busy, including SETTLE, any DRAIN cycle and the final handshake cycle:
  - The capture is ignored and overrun is set.
  - Snapshot and drain are unaffected.
- clr_overrun=1 clears overrun. If a set and a clear occur on the same edge, the set wins.
- Arithmetic: none. Words pass unmodified at full MAC_ACC_WIDTH; no sign handling.

Decomposition:
- Shared package (mac_pkg):
  - Localparam MAC_ACC_WIDTH default.
  - Drain state enum (IDLE=2'd0, SETTLE=2'd1, DRAIN=2'd2).
  - Lane-count constant NUM_LANES=4 and the index width derived from it.
- Single module, no sub-modules. The snapshot register bank plus 4:1 mux is inline; splitting it out adds no value.

Test Plan:
- Basic drain:
  - Stimulus: SETTLE_CYCLES=2; in0..in3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; capture at cycle 10; m_ready=1.
  - Response: acc_clear high cycle 13 only; beats 0x11111111..0x44444444 with idx 0..3 on cycles 13..16; m_last only on cycle 16; busy low from cycle 17.
- Backpressure:
  - Stimulus: as above, with m_ready low on cycles 13..15, then high.
  - Response: m_data=0x11111111, idx 0 held stable for 3 cycles; all four beats delivered in order; no duplicates.
- Snapshot isolation:
  - Stimulus: change in0..in3 to 0xDEADBEEF on the cycle after the snapshot.
  - Response: drained words are still the pre-change values.
- Overrun:
  - Stimulus: second capture during DRAIN (idx 2).
  - Response: overrun=1; stream unchanged; no second acc_clear.
  - Stimulus: clr_overrun and a new busy capture on the same edge.
  - Response: overrun stays 1.
- Zero settle:
  - Stimulus: SETTLE_CYCLES=0; capture at cycle 5.
  - Response: snapshot at the cycle-5 edge; acc_clear and first valid on cycle 6.
- Async reset mid-drain:
  - Stimulus: rst low between edges during idx 1.
  - Response: m_valid, busy and acc_clear drop immediately; after release, capture restarts cleanly at idx 0.
